// File: rtl/step_turn_ctrl.sv
// step_turn_ctrl: stepper-motor turn controller advancing a modulo-N player index per completed move.
// Define HOLD_TORQUE_EN to keep the coils energised on the last pattern while idle.
module step_turn_ctrl #(
    parameter int N_PLAYERS      = 3,
    parameter int STEPS_PER_TURN = 512,
    parameter int DIV            = 50000,
    parameter int CNT_W          = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req,
    input  logic                         dir,
    input  logic                         half_step,
    input  logic                         abort,
    output logic [3:0]                   phases,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(N_PLAYERS)-1:0] player
);
    localparam int PW = $clog2(N_PLAYERS);
    localparam int DW = $clog2(DIV);
    localparam logic [PW-1:0] PMAX = PW'(N_PLAYERS - 1);
    // idx 0 at the LSB nibble
    localparam logic [31:0] PT = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                  4'b0110, 4'b0100, 4'b1100, 4'b1000};
    typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;
    state_t state, state_n;
    logic [2:0] idx, idx_n, idx_t, stride;
    logic [CNT_W-1:0] rem, rem_n;
    logic [DW-1:0] presc, presc_n;
    logic dir_q, dir_n, half_q, half_n, busy_n, done_n, tick;
    logic [3:0] phases_n, idle_ph;
    logic [PW-1:0] player_n;
`ifdef HOLD_TORQUE_EN
    assign idle_ph = phases;
`else
    assign idle_ph = 4'b0000;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= '0;
            rem    <= '0;
            presc  <= '0;
            dir_q  <= 1'b0;
            half_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            phases <= 4'b0000;
            player <= '0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            rem    <= rem_n;
            presc  <= presc_n;
            dir_q  <= dir_n;
            half_q <= half_n;
            busy   <= busy_n;
            done   <= done_n;
            phases <= phases_n;
            player <= player_n;
        end
    end
    // An odd index in full-step mode takes a single half step to realign.
    assign tick   = presc == DW'(DIV - 1);
    assign stride = (half_q || idx[0]) ? 3'd1 : 3'd2;
    assign idx_t  = dir_q ? idx + stride : idx - stride;
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        rem_n    = rem;
        presc_n  = presc;
        dir_n    = dir_q;
        half_n   = half_q;
        busy_n   = busy;
        done_n   = 1'b0;
        phases_n = phases;
        player_n = player;
        case (state)
            IDLE: if (req && !abort) begin
                state_n  = RUN;
                dir_n    = dir;
                half_n   = half_step;
                rem_n    = CNT_W'(STEPS_PER_TURN);
                presc_n  = '0;
                busy_n   = 1'b1;
                phases_n = PT[{idx, 2'b00} +: 4];
            end
            RUN: if (abort) begin
                state_n  = IDLE;
                busy_n   = 1'b0;
                phases_n = idle_ph;
            end else if (tick) begin
                idx_n    = idx_t;
                rem_n    = rem - CNT_W'(1);
                presc_n  = '0;
                phases_n = PT[{idx_t, 2'b00} +: 4];
                state_n  = (rem == CNT_W'(1)) ? SETTLE : RUN;
            end else begin
                presc_n = presc + DW'(1);
            end
            SETTLE: if (abort || tick) begin
                state_n  = IDLE;
                busy_n   = 1'b0;
                phases_n = idle_ph;
                done_n   = !abort;
                player_n = abort ? player :
                           dir_q ? ((player == PMAX) ? '0 : player + PW'(1)) :
                                   ((player == '0) ? PMAX : player - PW'(1));
            end else begin
                presc_n = presc + DW'(1);
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_step_turn_ctrl.sv
// tb_step_turn_ctrl: randomized moves against an arithmetic model of step timing, index and player.
module tb_step_turn_ctrl;
    localparam int NP = 3;
    localparam int S  = 3;
    localparam int D  = 4;
    localparam int T  = (S + 1) * D;
`ifdef HOLD_TORQUE_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, req = 1'b0, dir = 1'b0, half_step = 1'b0, abort = 1'b0;
    logic [3:0] phases;
    logic busy, done;
    logic [1:0] player;
    int tests = 0, fails = 0;
    int m_player = 0, m_idx = 0;
    logic [3:0] m_idle = 4'b0000;
    logic [3:0] tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    step_turn_ctrl #(.N_PLAYERS(NP), .STEPS_PER_TURN(S), .DIV(D), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .dir(dir), .half_step(half_step),
        .abort(abort), .phases(phases), .busy(busy), .done(done), .player(player)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // index after n steps: half-step or odd index moves by one, otherwise by two
    function automatic int adv(input int i, input int n, input bit d, input bit h);
        int j = i;
        for (int k = 0; k < n; k++) begin
            int s = (h || (j % 2 == 1)) ? 1 : 2;
            j = (j + (d ? s : 8 - s)) % 8;
        end
        return j;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_ph", phases, m_idle);
            check("idle_player", player, m_player);
        end
    endtask

    // ab: edge that samples abort (0 = none); xr: edge with a stray req (0 = none)
    task automatic move(input bit d, input bit h, input int ab, input int xr);
        int i0, fin, n;
        bit aborted;
        i0 = m_idx;
        fin = adv(i0, S, d, h);
        aborted = 1'b0;
        req = 1'b1; dir = d; half_step = h;
        step();
        req = 1'b0; dir = 1'($urandom); half_step = 1'($urandom);
        check("start_ph", phases, tab[i0]);
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        for (int t = 1; t <= T; t++) begin
            abort = (t == ab);
            req = (t == xr);
            step();
            abort = 1'b0;
            req = 1'b0;
            if (t == ab) begin
                aborted = 1'b1;
                n = (ab - 1) / D;
                m_idx = adv(i0, n < S ? n : S, d, h);
                m_idle = HOLD ? tab[m_idx] : 4'b0000;
            end
            if (aborted) begin
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_ph", phases, m_idle);
            end else begin
                n = t / D;
                check("run_ph", phases, (t == T) ? (HOLD ? tab[fin] : 4'b0000) : tab[adv(i0, n < S ? n : S, d, h)]);
                check("run_busy", busy, t < T);
                check("run_done", done, t == T);
            end
        end
        if (!aborted) begin
            m_idx = fin;
            m_player = (m_player + (d ? 1 : NP - 1)) % NP;
            m_idle = HOLD ? tab[fin] : 4'b0000;
        end
        check("player", player, m_player);
    endtask

    initial begin
        int ab, xr;
        #2 reset = 1'b0;
        #1;
        check("rst_ph", phases, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_player", player, 0);
        step();
        step();
        check("rst_hold_ph", phases, 0);
        check("rst_hold_busy", busy, 0);
        check("rst_hold_player", player, 0);
        @(negedge clk) reset = 1'b1;
        idle(2);
        move(1, 1, 0, 0);
        check("first_player", player, 1);
        move(1, 1, 0, 2);
        move(1, 1, 0, 0);
        check("wrap_player", player, 0);
        move(1, 0, 0, 0);
        move(0, 1, 0, 0);
        move(0, 0, 0, 0);
        check("rev_wrap_player", player, 2);
        move(1, 1, 7, 2);
        idle(2);
        req = 1'b1; abort = 1'b1;
        step();
        req = 1'b0; abort = 1'b0;
        check("abort_req_busy", busy, 0);
        idle(3);
        repeat (40) begin
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, T) : 0;
            xr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, T - 1) : 0;
            if (ab != 0 && xr >= ab) xr = 0;
            move(1'($urandom), 1'($urandom), ab, xr);
            idle($urandom_range(0, 3));
        end
        req = 1'b1; dir = 1'b1; half_step = 1'b1;
        step();
        req = 1'b0;
        repeat (9) step();
        reset = 1'b0;
        #1;
        check("async_ph", phases, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_player", player, 0);
        step();
        @(negedge clk) reset = 1'b1;
        m_idx = 0; m_player = 0; m_idle = 4'b0000;
        idle(2);
        move(1, 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
